// File: rtl/randomizer_ctrl.sv
// randomizer_ctrl -- frame sequencer for the 4-bit-per-clock randomizer.
//
// Hunts for a start-of-frame nibble, reloads the randomizer seed at every
// frame boundary, then gates the randomizer enable so that exactly one
// nibble is scrambled per accepted upstream transfer. Scrambled nibbles
// leave through a one-deep valid/ready output stage with sof/eof tags.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   ctrl_en            1 = process frames; 0 = finish current frame, then idle
//   cfg_seed[_we]      seed register write; used by the next LOAD
//   clr_err            clears the sticky sync_err flag
//   s_valid/s_ready    upstream handshake; s_data nibble, s_sof frame start
//   rand_load/rand_en  randomizer controls; rand_seed = seed register
//   rand_in/rand_out   randomizer data in (= s_data) / registered out
//   m_valid/m_ready    downstream handshake; m_data = rand_out, m_sof/m_eof
//   frame_done         1-cycle pulse after the last nibble of a frame is accepted
//   frame_cnt          completed frames (wraps)
//   drop_cnt           nibbles dropped while hunting (saturates)
//   sync_err           sticky: SOF seen mid-frame
//   busy               state != IDLE
module randomizer_ctrl #(
  parameter int unsigned FRAME_NIBBLES = 376,
  parameter logic [14:0] DEFAULT_SEED  = 15'b100101010000000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_en,
  input  logic [14:0]      cfg_seed,
  input  logic             cfg_seed_we,
  input  logic             clr_err,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_data,
  input  logic             s_sof,
  output logic             rand_load,
  output logic             rand_en,
  output logic [14:0]      rand_seed,
  output logic [3:0]       rand_in,
  input  logic [3:0]       rand_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [3:0]       m_data,
  output logic             m_sof,
  output logic             m_eof,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             sync_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, HUNT, LOAD, RUN} state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_NIBBLES - 1);

  state_e           state_q, state_d;
  logic [14:0]      seed_q, seed_d;
  logic [CNT_W-1:0] nibble_cnt_q, nibble_cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_sof_q, m_sof_d;
  logic             m_eof_q, m_eof_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             sync_err_q, sync_err_d;

  logic slot_free, mid_sof, last_nib;

  // Output slot can take a new nibble if empty or being drained this cycle.
  assign slot_free = !m_valid_q || m_ready;
  // SOF arriving after the first nibble means upstream lost frame alignment.
  assign mid_sof   = s_valid && s_sof && (nibble_cnt_q != '0);
  assign last_nib  = (nibble_cnt_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    seed_d       = cfg_seed_we ? cfg_seed : seed_q;
    nibble_cnt_d = nibble_cnt_q;
    m_sof_d      = m_sof_q;
    m_eof_d      = m_eof_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    sync_err_d   = clr_err ? 1'b0 : sync_err_q;
    s_ready      = 1'b0;
    rand_load    = 1'b0;
    rand_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl_en) state_d = HUNT;
      end
      HUNT: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (s_valid) begin
          if (s_sof) begin
            // SOF nibble is left on the bus; it is taken in RUN after LOAD.
            state_d = LOAD;
          end else begin
            s_ready = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD: begin
        rand_load    = 1'b1;
        nibble_cnt_d = '0;
        state_d      = RUN;
      end
      RUN: begin
        s_ready = slot_free && !mid_sof;
        rand_en = s_valid && s_ready;
        if (mid_sof) begin
          // Abandon the partial frame and restart on this SOF.
          sync_err_d = 1'b1;
          state_d    = LOAD;
        end else if (rand_en) begin
          m_sof_d = (nibble_cnt_q == '0);
          m_eof_d = last_nib;
          if (last_nib) begin
            nibble_cnt_d = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            state_d      = ctrl_en ? HUNT : IDLE;
          end else begin
            nibble_cnt_d = nibble_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // New nibble replaces the old one when both happen in the same cycle.
    m_valid_d = rand_en || (m_valid_q && !m_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      seed_q       <= DEFAULT_SEED;
      nibble_cnt_q <= '0;
      m_valid_q    <= 1'b0;
      m_sof_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      nibble_cnt_q <= nibble_cnt_d;
      m_valid_q    <= m_valid_d;
      m_sof_q      <= m_sof_d;
      m_eof_q      <= m_eof_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign rand_seed  = seed_q;
  assign rand_in    = s_data;
  assign m_data     = rand_out;
  assign m_valid    = m_valid_q;
  assign m_sof      = m_sof_q;
  assign m_eof      = m_eof_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign sync_err   = sync_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_randomizer_ctrl.sv
// Directed bench for randomizer_ctrl with an 8-nibble frame. A tiny
// randomizer model registers rand_in ^ seed[7:4] on rand_en, so the
// scrambled value also reveals which seed the last LOAD used.
module tb_randomizer_ctrl;
  localparam int          N   = 8;
  localparam logic [14:0] DEF = 15'b100101010000000;

  logic        clk = 1'b0, rst = 1'b0, ctrl_en = 1'b0, cfg_seed_we = 1'b0, clr_err = 1'b0;
  logic        s_valid = 1'b0, s_sof = 1'b0;
  logic [14:0] cfg_seed = '0;
  logic [3:0]  s_data = '0;
  logic        s_ready, rand_load, rand_en, m_valid, m_ready, m_sof, m_eof;
  logic        frame_done, sync_err, busy;
  logic [14:0] rand_seed, sc;
  logic [3:0]  rand_in, rand_out, m_data;
  logic [15:0] frame_cnt, drop_cnt;

  logic rdy_fix = 1'b1, tog_en = 1'b0;
  int   cyc_n = 0;
  assign m_ready = tog_en ? (cyc_n % 3 == 0) : rdy_fix;

  randomizer_ctrl #(.FRAME_NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .cfg_seed(cfg_seed),
    .cfg_seed_we(cfg_seed_we), .clr_err(clr_err), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .rand_load(rand_load),
    .rand_en(rand_en), .rand_seed(rand_seed), .rand_in(rand_in),
    .rand_out(rand_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eof(m_eof), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .sync_err(sync_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // randomizer model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sc       <= DEF;
      rand_out <= '0;
    end else begin
      if (rand_load) sc <= rand_seed;
      if (rand_en) rand_out <= rand_in ^ sc[7:4];
    end
  end

  // event counters and delivery log
  int          n_load = 0, n_en = 0, n_done = 0, dlv_n = 0;
  logic [14:0] ld_seed = '0;
  logic [5:0]  dlv [0:255];
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rand_load) begin
      n_load  <= n_load + 1;
      ld_seed <= rand_seed;
    end
    if (rand_en) n_en <= n_en + 1;
    if (frame_done) n_done <= n_done + 1;
    if (m_valid && m_ready) begin
      dlv[dlv_n] <= {m_sof, m_eof, m_data};
      dlv_n      <= dlv_n + 1;
    end
  end

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] nd(input int f, input int i);
    return 4'(f * 5 + i);
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  logic       stl_prev = 1'b0;
  logic [6:0] stl_val  = '0;

  // Present one nibble until accepted; w = cycles taken.
  task automatic push(input logic [3:0] d, input logic sof, output int w);
    logic got;
    got = 1'b0; w = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (stl_prev) chk("stall_hold", {m_valid, m_sof, m_eof, m_data}, stl_val);
      stl_prev = m_valid & ~m_ready;
      stl_val  = {m_valid, m_sof, m_eof, m_data};
      if (stl_prev) chk("stall_rdy", s_ready, 0);
      got = s_ready;
      w++;
      @(posedge clk); #1;
    end
    if (!got) chk("push_timeout", got, 1);
  endtask

  task automatic send_frame(input int f, output int gaps, output int w0);
    int w;
    stl_prev = 1'b0; gaps = 0; w0 = 0;
    for (int i = 0; i < N; i++) begin
      push(nd(f, i), i == 0, w);
      if (i == 0) w0 = w; else gaps += w;
    end
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!m_valid) break;
    end
    chk("drain", m_valid, 0);
    cyc();
  endtask

  task automatic chk_frame(input int base, input int f, input logic [3:0] scr);
    logic [5:0] e;
    for (int i = 0; i < N; i++) begin
      e = {i == 0, i == N - 1, nd(f, i) ^ scr};
      chk("dlv", dlv[base + i], e);
    end
  endtask

  initial begin
    int b, l0, e0, d0, g, w0, w;
    // reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_load", rand_load, 0);
    chk("rst_en", rand_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_sof_eof", {m_sof, m_eof}, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seed", rand_seed, DEF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; ctrl_en = 1'b1;

    // two back-to-back frames, full throughput
    b = dlv_n; l0 = n_load; e0 = n_en; d0 = n_done;
    send_frame(0, g, w0);
    chk("t1_w0_first", w0, 4);
    chk("t1_gaps0", g, N - 1);
    send_frame(1, g, w0);
    chk("t1_w0_second", w0, 3);
    chk("t1_gaps1", g, N - 1);
    drain();
    chk("t1_dlv_n", dlv_n - b, 2 * N);
    chk_frame(b, 0, 4'h8);
    chk_frame(b + N, 1, 4'h8);
    chk("t1_loads", n_load - l0, 2);
    chk("t1_en", n_en - e0, 2 * N);
    chk("t1_done", n_done - d0, 2);
    chk("t1_frame_cnt", frame_cnt, 2);

    // downstream backpressure 1,0,0 pattern
    tog_en = 1'b1;
    b = dlv_n;
    send_frame(2, g, w0);
    drain();
    tog_en = 1'b0;
    chk("t2_dlv_n", dlv_n - b, N);
    chk_frame(b, 2, 4'h8);
    chk("t2_frame_cnt", frame_cnt, 3);

    // hunting: three drops, then SOF held through LOAD
    b = dlv_n;
    s_valid = 1'b1; s_sof = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_data = 4'(4'hC + k);
      @(negedge clk);
      chk("t3_drop_rdy", s_ready, 1);
      chk("t3_drop_en", rand_en, 0);
      cyc();
    end
    s_sof = 1'b1; s_data = nd(3, 0);
    @(negedge clk);
    chk("t3_sof_hold", s_ready, 0);
    cyc();
    @(negedge clk);
    chk("t3_load", {rand_load, s_ready, rand_en}, 3'b100);
    cyc();
    @(negedge clk);
    chk("t3_accept", {rand_load, s_ready, rand_en}, 3'b011);
    cyc();
    for (int i = 1; i < N; i++) push(nd(3, i), 1'b0, w);
    s_valid = 1'b0; s_sof = 1'b0;
    drain();
    chk("t3_drop_cnt", drop_cnt, 3);
    chk("t3_dlv_n", dlv_n - b, N);
    chk_frame(b, 3, 4'h8);
    chk("t3_frame_cnt", frame_cnt, 4);

    // SOF at nibble 5 -> resync
    b = dlv_n; l0 = n_load;
    for (int i = 0; i < 5; i++) push(nd(4, i), i == 0, w);
    push(nd(5, 0), 1'b1, w);
    chk("t4_resync_w", w, 3);
    chk("t4_sync_err", sync_err, 1);
    chk("t4_frame_cnt_kept", frame_cnt, 4);
    for (int i = 1; i < N; i++) push(nd(5, i), 1'b0, w);
    s_valid = 1'b0; s_sof = 1'b0;
    drain();
    chk("t4_dlv_n", dlv_n - b, 5 + N);
    chk("t4_partial_tail", dlv[b + 4], {2'b00, nd(4, 4) ^ 4'h8});
    chk_frame(b + 5, 5, 4'h8);
    chk("t4_frame_cnt", frame_cnt, 5);
    chk("t4_loads", n_load - l0, 2);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("t4_clr_err", sync_err, 0);

    // seed write mid-frame, used by the next LOAD only
    b = dlv_n;
    for (int i = 0; i < 3; i++) push(nd(6, i), i == 0, w);
    cfg_seed = 15'h1234; cfg_seed_we = 1'b1;
    push(nd(6, 3), 1'b0, w);
    cfg_seed_we = 1'b0;
    chk("t5_seed_reg", rand_seed, 15'h1234);
    for (int i = 4; i < N; i++) push(nd(6, i), 1'b0, w);
    s_valid = 1'b0; s_sof = 1'b0;
    send_frame(7, g, w0);
    drain();
    chk("t5_dlv_n", dlv_n - b, 2 * N);
    chk_frame(b, 6, 4'h8);
    chk_frame(b + N, 7, 4'h3);
    chk("t5_load_seed", ld_seed, 15'h1234);
    chk("t5_frame_cnt", frame_cnt, 7);

    // asynchronous reset mid-frame, then a clean frame
    for (int i = 0; i < 5; i++) push(nd(8, i), i == 0, w);
    rst = 1'b1;
    #1;
    chk("t6_m_valid", m_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_s_ready", s_ready, 0);
    chk("t6_cnts", {frame_cnt, drop_cnt}, 0);
    chk("t6_seed", rand_seed, DEF);
    s_valid = 1'b0; s_sof = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    b = dlv_n;
    send_frame(9, g, w0);
    chk("t6_w0", w0, 4);
    drain();
    chk("t6_dlv_n", dlv_n - b, N);
    chk_frame(b, 9, 4'h8);
    chk("t6_frame_cnt", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
